pcileech_tx_arbiter: RTL and testbench

PCILEECH_TX_ARBITER -- requirements
Module: pcileech_tx_arbiter

---
 rtl/pcileech_header.sv | 27 ++
 rtl/pcileech_rr_pick.sv | 28 ++
 rtl/pcileech_tx_arbiter.sv | 97 +++++++++
 tb/tb_pcileech_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_header.sv
// Shared definitions for the PCILeech TX path: source ids, source count and the
// round-robin successor used by the arbiter.
package pcileech_header;

    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {
        SRC_CFG  = 2'd0,
        SRC_TLP  = 2'd1,
        SRC_CORE = 2'd2
    } src_id_e;

    typedef enum logic {
        StIdle,
        StGrant
    } arb_state_e;

    // Successor in rotation 0 -> 1 -> 2 -> 0; the unused code 3 folds back to 0.
    function automatic src_id_e rr_next(input src_id_e id);
        case (id)
            SRC_CFG: return SRC_TLP;
            SRC_TLP: return SRC_CORE;
            default: return SRC_CFG;
        endcase
    endfunction

endpackage

// File: rtl/pcileech_rr_pick.sv
// Combinational round-robin pick: first valid source starting after last_id.
module pcileech_rr_pick
    import pcileech_header::*;
(
    input  logic [NUM_SRC-1:0] valid,
    input  src_id_e            last_id,
    output src_id_e            pick_id,
    output logic               any_valid
);

    src_id_e cand;
    logic    found;

    always_comb begin
        pick_id = rr_next(last_id);
        cand    = last_id;
        found   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = rr_next(cand);
            if (!found && valid[cand]) begin
                pick_id = cand;
                found   = 1'b1;
            end
        end
        any_valid = |valid;
    end

endmodule

// File: rtl/pcileech_tx_arbiter.sv
// Three-source packet arbiter toward the COM FIFO: round-robin grant per packet
// (or per burst limit) and a single 1-cycle output register.
module pcileech_tx_arbiter
    import pcileech_header::*;
#(
    parameter int unsigned PARAM_MAX_BURST = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0][31:0]  src_data,
    input  logic [NUM_SRC-1:0]        src_last,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      out_valid,
    output logic [31:0]               out_data,
    output logic [1:0]                out_src,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      grant_active
);

    localparam logic [7:0] BurstLast = 8'(PARAM_MAX_BURST - 1);

    arb_state_e state_q;
    src_id_e    grant_id_q;
    src_id_e    last_id_q;
    logic [7:0] burst_cnt_q;
    logic       armed_q;

    src_id_e    pick_id;
    logic       any_valid;
    logic       accept;
    logic       release_grant;

    pcileech_rr_pick u_rr_pick (
        .valid     (src_valid),
        .last_id   (last_id_q),
        .pick_id   (pick_id),
        .any_valid (any_valid)
    );

    always_comb begin
        src_ready = '0;
        if (state_q == StGrant && (!out_valid || out_ready)) begin
            src_ready[grant_id_q] = 1'b1;
        end
    end

    assign accept        = src_valid[grant_id_q] && src_ready[grant_id_q];
    assign release_grant = accept && (src_last[grant_id_q] || burst_cnt_q == BurstLast);
    assign grant_active  = (state_q == StGrant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_id_q  <= SRC_CFG;
            last_id_q   <= SRC_CORE;
            burst_cnt_q <= '0;
            armed_q     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_src     <= '0;
            out_last    <= 1'b0;
        end else begin
            // Blocks a grant on the first edge after reset release.
            armed_q <= 1'b1;

            if (accept) begin
                out_valid   <= 1'b1;
                out_data    <= src_data[grant_id_q];
                out_src     <= grant_id_q;
                out_last    <= src_last[grant_id_q];
                burst_cnt_q <= burst_cnt_q + 8'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (armed_q && any_valid) begin
                        grant_id_q  <= pick_id;
                        burst_cnt_q <= '0;
                        state_q     <= StGrant;
                    end
                end
                StGrant: begin
                    if (release_grant) begin
                        last_id_q <= grant_id_q;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_tx_arbiter.sv
// Directed bench for pcileech_tx_arbiter with PARAM_MAX_BURST = 4.
module tb_pcileech_tx_arbiter;

    typedef struct packed {
        logic [1:0]  src;
        logic        last;
        logic [31:0] data;
        int          cyc;
    } rec_t;

    logic             clk;
    logic             rst_n;
    logic [2:0]       src_valid;
    logic [2:0][31:0] src_data;
    logic [2:0]       src_last;
    logic [2:0]       src_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [1:0]       out_src;
    logic             out_last;
    logic             out_ready;
    logic             grant_active;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] q2[$];
    rec_t        obs[$];
    rec_t        exp_q[$];
    int          n_checks;
    int          n_errors;
    int          cyc;

    pcileech_tx_arbiter #(.PARAM_MAX_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .grant_active (grant_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source driver: pops a word after its handshake, presents the queue head.
    initial begin
        logic [2:0] fire;
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        forever begin
            @(negedge clk);
            fire = src_valid & src_ready;
            @(posedge clk);
            #2;
            if (fire[0] && q0.size() > 0) q0.delete(0);
            if (fire[1] && q1.size() > 0) q1.delete(0);
            if (fire[2] && q2.size() > 0) q2.delete(0);
            src_valid[0] = (q0.size() > 0);
            src_valid[1] = (q1.size() > 0);
            src_valid[2] = (q2.size() > 0);
            if (src_valid[0]) {src_last[0], src_data[0]} = q0[0];
            if (src_valid[1]) {src_last[1], src_data[1]} = q1[0];
            if (src_valid[2]) {src_last[2], src_data[2]} = q2[0];
        end
    end

    // Output monitor: records each word that will transfer on the next edge.
    initial begin
        rec_t r;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && out_valid && out_ready) begin
                r.src  = out_src;
                r.last = out_last;
                r.data = out_data;
                r.cyc  = cyc;
                obs.push_back(r);
            end
        end
    end

    task automatic push(input int s, input logic [31:0] d, input logic l);
        case (s)
            0:       q0.push_back({l, d});
            1:       q1.push_back({l, d});
            default: q2.push_back({l, d});
        endcase
    endtask

    task automatic expect_word(input logic [1:0] s, input logic [31:0] d, input logic l);
        rec_t r;
        r.src  = s;
        r.last = l;
        r.data = d;
        r.cyc  = 0;
        exp_q.push_back(r);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #1;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic wait_obs(input string tag, input int n, input int budget);
        int t = 0;
        while (obs.size() < n && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(tag, obs.size(), n);
    endtask

    task automatic compare_obs(input string tag, input int gap);
        int n;
        check($sformatf("%s_count", tag), obs.size(), exp_q.size());
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_src%0d", tag, i), obs[i].src, exp_q[i].src);
            check($sformatf("%s_data%0d", tag, i), obs[i].data, exp_q[i].data);
            check($sformatf("%s_last%0d", tag, i), obs[i].last, exp_q[i].last);
            if (gap > 0 && i > 0) begin
                check($sformatf("%s_gap%0d", tag, i), obs[i].cyc - obs[i-1].cyc, gap);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        check("rst_out_last", out_last, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_grant", grant_active, 0);

        // Single 4-word packet from src 1, plus earliest-grant check.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(1, 32'hA0 + i, i == 3);
            expect_word(2'd1, 32'hA0 + i, i == 3);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("first_grant_early", grant_active, 0);
        check("first_ready_early", src_ready, 0);
        @(posedge clk);
        #1;
        wait_obs("pkt_wait", 4, 30);
        compare_obs("pkt", 1);
        repeat (3) @(posedge clk);
        #1;
        check("pkt_idle_after", grant_active, 0);

        // Contention: all sources with 1-word packets -> 0,1,2,0,1,2.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push(0, 32'hC0 + k, 1'b1);
            push(1, 32'hD0 + k, 1'b1);
            push(2, 32'hE0 + k, 1'b1);
        end
        expect_word(2'd0, 32'hC0, 1'b1);
        expect_word(2'd1, 32'hD0, 1'b1);
        expect_word(2'd2, 32'hE0, 1'b1);
        expect_word(2'd0, 32'hC1, 1'b1);
        expect_word(2'd1, 32'hD1, 1'b1);
        expect_word(2'd2, 32'hE1, 1'b1);
        rst_n = 1'b1;
        wait_obs("rr_wait", 6, 60);
        compare_obs("rr", 2);

        // Burst limit 4: 10-word packet on src 0 interleaved with src 2.
        do_reset();
        for (int i = 0; i < 10; i++) push(0, 32'h100 + i, i == 9);
        for (int j = 0; j < 3; j++) push(2, 32'h200 + j, 1'b1);
        for (int i = 0; i < 4; i++) expect_word(2'd0, 32'h100 + i, 1'b0);
        expect_word(2'd2, 32'h200, 1'b1);
        for (int i = 4; i < 8; i++) expect_word(2'd0, 32'h100 + i, 1'b0);
        expect_word(2'd2, 32'h201, 1'b1);
        expect_word(2'd0, 32'h108, 1'b0);
        expect_word(2'd0, 32'h109, 1'b1);
        expect_word(2'd2, 32'h202, 1'b1);
        rst_n = 1'b1;
        wait_obs("burst_wait", 13, 100);
        compare_obs("burst", 0);

        // Backpressure for 5 cycles while word 0x302 sits in the output register.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(1, 32'h300 + i, i == 7);
            expect_word(2'd1, 32'h300 + i, i == 7);
        end
        rst_n = 1'b1;
        wait_obs("bp_start", 2, 30);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", i), out_valid, 1);
            check($sformatf("bp_data%0d", i), out_data, 32'h302);
            check($sformatf("bp_ready%0d", i), src_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_obs("bp_wait", 8, 60);
        repeat (5) @(posedge clk);
        #1;
        compare_obs("bp", 0);

        // Stall: granted src 1 runs dry mid-packet while src 0 waits.
        do_reset();
        push(1, 32'h400, 1'b0);
        push(1, 32'h401, 1'b0);
        rst_n = 1'b1;
        begin
            int t = 0;
            while (!grant_active && t < 10) begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        check("stall_grant", grant_active, 1);
        push(0, 32'h500, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("stall_held%0d", i), grant_active, 1);
            check($sformatf("stall_src0_ready%0d", i), src_ready[0], 0);
        end
        @(posedge clk);
        #1;
        push(1, 32'h402, 1'b0);
        push(1, 32'h403, 1'b1);
        for (int i = 0; i < 4; i++) expect_word(2'd1, 32'h400 + i, i == 3);
        expect_word(2'd0, 32'h500, 1'b1);
        wait_obs("stall_wait", 5, 40);
        compare_obs("stall", 0);

        // Asynchronous reset mid-burst, between clock edges.
        do_reset();
        for (int i = 0; i < 10; i++) push(0, 32'h600 + i, i == 9);
        rst_n = 1'b1;
        wait_obs("ar_start", 2, 30);
        #1;
        check("ar_pre_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ready", src_ready, 0);
        check("ar_grant", grant_active, 0);
        do_reset();
        push(0, 32'h700, 1'b1);
        push(1, 32'h701, 1'b1);
        push(2, 32'h702, 1'b1);
        rst_n = 1'b1;
        wait_obs("ar_wait", 1, 30);
        if (obs.size() > 0) begin
            check("ar_first_src", obs[0].src, 0);
            check("ar_first_data", obs[0].data, 32'h700);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
